// File: rtl/serial_pkg.sv
// serial_pkg: constants shared by the serial link receiver and transmitter
package serial_pkg;
    localparam int BYTE_W          = 8;
    localparam int BIT_CNT_W       = 3;
    localparam int DEFAULT_TIMEOUT = 4096;
endpackage

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: small byte FIFO; caller must not push when full unless popping in the same cycle
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = din;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
    end
    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end
endmodule

// File: rtl/serialin.sv
// serialin: two-wire gated-clock serial receiver with idle-timeout framing recovery and byte FIFO
module serialin
    import serial_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              sdata,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, sdata_sync_q, sdata_sync_d;
    logic                   prev_q, prev_d;
    logic [BYTE_W-1:0]      sr_q, sr_d, byte_w;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                   sclk_s, sdata_s, fall, done, pop, push, empty, full;
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign fall    = prev_q & ~sclk_s;
    assign byte_w  = {sdata_s, sr_q[BYTE_W-1:1]};
    assign done    = fall && (bit_cnt_q == '1);
    assign pop     = ~empty & data_ready;
    assign push    = done & (~full | pop);
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        prev_d       = sclk_s;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q | (done & full & ~pop);
        // A fall wins over a timeout expiring in the same cycle
        if (fall) begin
            sr_d      = byte_w;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            to_cnt_d  = '0;
        end else if (bit_cnt_q == '0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            prev_q       <= 1'b0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            prev_q       <= prev_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end
    serial_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (byte_w),
        .pop   (pop),
        .dout  (data_out),
        .empty (empty),
        .full  (full)
    );
    assign data_valid = ~empty;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign busy       = bit_cnt_q != '0;
endmodule

// File: tb/tb_serialin.sv
// tb_serialin: directed bench for serialin, 64-clk bit period, outputs sampled on falling clk
module tb_serialin;
    logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, sdata = 1'b0, data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, overrun, frame_err, busy;
    int         checks = 0, errors = 0;
    serialin dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .sdata      (sdata),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sdata = b[i];
            cyc(16);
            sclk = 1'b1;
            cyc(32);
            sclk = 1'b0;
            cyc(16);
        end
    endtask
    task automatic last_fall(input logic [7:0] b);
        sdata = b[7];
        cyc(16);
        sclk = 1'b1;
        cyc(32);
        sclk = 1'b0;
    endtask
    task automatic drain(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, data_valid, 1'b1);
        chk({tag, "_data"}, data_out, exp);
        data_ready = 1'b1;
        cyc(1);
        data_ready = 1'b0;
    endtask
    task automatic pulse_rst();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask
    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        data_ready = 1'b1;
        send_bits(8'hA5, 7);
        chk("a5_busy_mid", busy, 1'b1);
        last_fall(8'hA5);
        cyc(1);
        chk("a5_lat_e0", data_valid, 1'b0);
        cyc(1);
        chk("a5_lat_e1", data_valid, 1'b0);
        cyc(1);
        chk("a5_lat_e2", data_valid, 1'b1);
        chk("a5_data", data_out, 8'hA5);
        cyc(1);
        chk("a5_pulse_end", data_valid, 1'b0);
        chk("a5_busy_after", busy, 1'b0);
        chk("a5_overrun", overrun, 1'b0);
        chk("a5_frame", frame_err, 1'b0);
        cyc(16);
        data_ready = 1'b0;
        send_bits(8'h01, 8);
        send_bits(8'h80, 8);
        chk("b2b_valid", data_valid, 1'b1);
        chk("b2b_head", data_out, 8'h01);
        data_ready = 1'b1;
        cyc(1);
        chk("b2b_second_valid", data_valid, 1'b1);
        chk("b2b_second", data_out, 8'h80);
        cyc(1);
        chk("b2b_empty", data_valid, 1'b0);
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bits(8'h10 + 8'(i), 8);
        chk("ovr_overrun", overrun, 1'b1);
        chk("ovr_frame", frame_err, 1'b0);
        for (int i = 0; i < 4; i++) drain("ovr_drain", 8'h10 + 8'(i));
        chk("ovr_empty", data_valid, 1'b0);
        pulse_rst();
        for (int i = 0; i < 4; i++) send_bits(8'h10 + 8'(i), 8);
        chk("full_no_overrun", overrun, 1'b0);
        send_bits(8'h14, 7);
        last_fall(8'h14);
        cyc(2);
        data_ready = 1'b1;
        cyc(1);
        data_ready = 1'b0;
        cyc(16);
        chk("pushpop_overrun", overrun, 1'b0);
        for (int i = 1; i < 5; i++) drain("pushpop_drain", 8'h10 + 8'(i));
        chk("pushpop_empty", data_valid, 1'b0);
        send_bits(8'h07, 3);
        chk("to_busy", busy, 1'b1);
        cyc(4000);
        chk("to_early_frame", frame_err, 1'b0);
        chk("to_early_busy", busy, 1'b1);
        cyc(200);
        chk("to_frame", frame_err, 1'b1);
        chk("to_busy_clr", busy, 1'b0);
        send_bits(8'h3C, 8);
        drain("to_next", 8'h3C);
        chk("to_next_empty", data_valid, 1'b0);
        pulse_rst();
        send_bits(8'hFF, 5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame", frame_err, 1'b0);
        send_bits(8'h5A, 8);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_frame2", frame_err, 1'b0);
        drain("midrst_byte", 8'h5A);
        chk("midrst_empty", data_valid, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
